io_responder: RTL and testbench
===============================

# io_responder

Memory-mapped I/O responder on the processor's data-memory bus (12-bit word address, 32-bit write data, write enable, 32-bit read data). It is the target end of the processor's load/store traffic for a 16-word I/O window; dmem serves every other address. It provides a free-running cycle counter, a countdown timer with a sticky expiry flag, a 4-entry input-event FIFO fed by the board input logic, and a 16-bit LED output register. Read data is registered to match dmem's one-cycle syncram latency.

## Interface
Parameters:
- BASE_ADDR, 12'hF00: base of the I/O window; decode uses address[11:4] == BASE_ADDR[11:4].
- FIFO_DEPTH, 4: event FIFO entries (power of two).
- EVT_WIDTH, 8: event payload width.

Ports:
- clock  in  1  single clock for all state.
- reset  in  1  asynchronous, active-low (0 = reset).
- req  in  1  one-cycle strobe qualifying address/data/wren; exactly one strobe per processor access.
- address  in  12  word address from processor.
- data  in  32  write data.
- wren  in  1  1 = write, 0 = read (valid with req).
- q  out  32  registered read data.
- hit  out  1  registered: previous-cycle req decoded inside the window (dmem/io read mux select).
- evt_valid  in  1  producer has an event.
- evt_data  in  EVT_WIDTH  event payload.
- evt_ready  out  1  FIFO can accept.
- led_out  out  16  LED register.
- irq  out  1  equals timer expired flag.

## Operation
Register map, offset = address[3:0]:
- 0 CYCLE (RO): 32-bit counter, +1 every clock, wraps 0xFFFFFFFF→0.
- 1 TIMER_LOAD (WO, reads current count): write N>0 loads count=N, running=1; N=0 stops timer (count=0, running=0), expired unchanged.
- 2 TIMER_STATUS: read {30'b0, running, expired}; write with data[0]=1 clears expired.
- 3 EVT_POP (RO, side effect): non-empty → q={1'b1, 31-EVT_WIDTH zeros, head}, pop; empty → q=0, no change.
- 4 EVT_COUNT (RO): occupancy (0..FIFO_DEPTH).
- 5 LED (RW): write stores data[15:0]; read {16'b0, led_out}.
- 6..15: read 0, writes ignored. Writes to RO offsets ignored.
- Accesses outside the window: no state change, hit=0, q=0.
- Timer: while running, count decrements each cycle; on the cycle count==1, next state count=0, running=0, expired=1.
- FIFO push: evt_valid & evt_ready. evt_ready = (occupancy < FIFO_DEPTH) and reset deasserted; pop in the same cycle does not raise evt_ready.
- Simultaneous push+pop (not empty, not full): occupancy unchanged, popped entry is the old head.
- Push into empty + pop same cycle: pop sees empty (returns 0), push lands.

## Timing
- Read latency 1: req at edge t → q, hit valid after edge t+1, held until next req.
- Reads sample state before that edge's updates (CYCLE returns value at edge t; EVT_COUNT is pre-push/pop).
- Write effects visible from edge t+1.
- Expire and status-clear in same cycle: expire wins (expired=1).
- TIMER_LOAD write in the cycle of expiry: load wins, expired still sets.
- Reset (async assert, sync release): q=0, hit=0, CYCLE=0, count=0, running=0, expired=0, irq=0, led_out=0, FIFO empty, evt_ready=0. Reset mid-timer or with FIFO non-empty discards all state.

## Structure
- Package io_pkg: BASE_ADDR default, register offset constants (OFF_CYCLE..OFF_LED), FIFO status bit position.
- Sub-module io_event_fifo: synchronous FIFO (push/pop, head, count, full/empty), wrap-around pointers with extra MSB for full/empty.
- Top: decode, timer, cycle counter, LED reg, read mux and q register.

## Test plan
- Reset release, read offset 0 twice 10 cycles apart → values differ by 10; preload wrap case 0xFFFFFFFF→0.
- Write TIMER_LOAD=5 at t → running=1, expired and irq rise at t+5; STATUS read → 0x1; write STATUS=1 → irq=0.
- Push 0x11,0x22,0x33,0x44 → evt_ready=0, EVT_COUNT=4; 5th event held; pop → 0x80000011, evt_ready returns 1 next cycle.
- Pop empty FIFO → q=0, count stays 0; push+pop same cycle on count=2 → count stays 2, FIFO order preserved.
- Write LED=0xABCD1234 → led_out=0x1234; read 0x00001234; write to 0xE00 → led_out unchanged, hit=0.
- Assert reset mid-countdown with FIFO count=3 → all outputs 0 immediately, FIFO empty after release.

Source files
------------

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared constants for the memory-mapped I/O responder
package io_pkg;

    localparam logic [11:0] IO_BASE_ADDR = 12'hF00;

    localparam logic [3:0] OFF_CYCLE        = 4'd0;
    localparam logic [3:0] OFF_TIMER_LOAD   = 4'd1;
    localparam logic [3:0] OFF_TIMER_STATUS = 4'd2;
    localparam logic [3:0] OFF_EVT_POP      = 4'd3;
    localparam logic [3:0] OFF_EVT_COUNT    = 4'd4;
    localparam logic [3:0] OFF_LED          = 4'd5;

    // Bit of the EVT_POP read word that flags a valid popped event
    localparam int EVT_VALID_BIT = 31;

endpackage

// File: rtl/io_event_fifo.sv
// rtl/io_event_fifo.sv - synchronous event FIFO with extra-MSB wrap pointers
module io_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Pop is qualified on the pre-edge empty flag, so a push into an empty FIFO cannot be popped in the same cycle
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        count    = wr_ptr_q - rd_ptr_q;
        head     = mem_q[rd_ptr_q[AW-1:0]];
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/io_responder.sv
// rtl/io_responder.sv - I/O window target: cycle counter, timer, event FIFO, LED register
module io_responder
    import io_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR  = IO_BASE_ADDR,
    parameter int          FIFO_DEPTH = 4,
    parameter int          EVT_WIDTH  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req,
    input  logic [11:0]          address,
    input  logic [31:0]          data,
    input  logic                 wren,
    output logic [31:0]          q,
    output logic                 hit,
    input  logic                 evt_valid,
    input  logic [EVT_WIDTH-1:0] evt_data,
    output logic                 evt_ready,
    output logic [15:0]          led_out,
    output logic                 irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic        sel, rd, wr, expire;
    logic [3:0]  off;
    logic [31:0] rdata;

    logic [31:0] cycle_q, cycle_d;
    logic [31:0] count_q, count_d;
    logic        running_q, running_d;
    logic        expired_q, expired_d;
    logic [15:0] led_q, led_d;
    logic [31:0] q_q, q_d;
    logic        hit_q, hit_d;

    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [EVT_WIDTH-1:0] fifo_head;
    logic [CW-1:0]        fifo_count;

    io_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_WIDTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (evt_data),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        sel       = req && (address[11:4] == BASE_ADDR[11:4]);
        off       = address[3:0];
        wr        = sel && wren;
        rd        = sel && !wren;
        evt_ready = reset && !fifo_full;
        fifo_push = evt_valid && evt_ready;
        fifo_pop  = rd && (off == OFF_EVT_POP) && !fifo_empty;
    end

    // Read mux samples pre-edge state; the q register supplies the one-cycle latency
    always_comb begin
        rdata = '0;
        case (off)
            OFF_CYCLE:        rdata = cycle_q;
            OFF_TIMER_LOAD:   rdata = count_q;
            OFF_TIMER_STATUS: rdata = {30'd0, running_q, expired_q};
            OFF_EVT_POP: begin
                if (!fifo_empty) begin
                    rdata[EVT_VALID_BIT]    = 1'b1;
                    rdata[EVT_WIDTH-1:0]    = fifo_head;
                end
            end
            OFF_EVT_COUNT:    rdata = 32'(fifo_count);
            OFF_LED:          rdata = {16'd0, led_q};
            default:          rdata = '0;
        endcase
    end

    // Expiry beats a same-cycle status clear; a same-cycle load still restarts the count
    always_comb begin
        expire    = running_q && (count_q == 32'd1);
        count_d   = count_q;
        running_d = running_q;
        expired_d = expired_q;
        if (running_q) begin
            count_d = count_q - 32'd1;
            if (expire) begin
                running_d = 1'b0;
                expired_d = 1'b1;
            end
        end
        if (wr && (off == OFF_TIMER_STATUS) && data[0] && !expire) begin
            expired_d = 1'b0;
        end
        if (wr && (off == OFF_TIMER_LOAD)) begin
            count_d   = data;
            running_d = (data != 32'd0);
        end
    end

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        led_d   = (wr && (off == OFF_LED)) ? data[15:0] : led_q;
        hit_d   = req ? sel : hit_q;
        q_d     = req ? (rd ? rdata : 32'd0) : q_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_q   <= '0;
            count_q   <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            led_q     <= '0;
            q_q       <= '0;
            hit_q     <= 1'b0;
        end else begin
            cycle_q   <= cycle_d;
            count_q   <= count_d;
            running_q <= running_d;
            expired_q <= expired_d;
            led_q     <= led_d;
            q_q       <= q_d;
            hit_q     <= hit_d;
        end
    end

    assign q       = q_q;
    assign hit     = hit_q;
    assign led_out = led_q;
    assign irq     = expired_q;

endmodule

// File: tb/tb_io_responder.sv
// tb/tb_io_responder.sv - randomized bench with a behavioural model for io_responder
module tb_io_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        wren = 1'b0;
    logic        evt_valid = 1'b0;
    logic [11:0] address = '0;
    logic [31:0] data = '0;
    logic [7:0]  evt_data = '0;
    logic [31:0] q;
    logic        hit, evt_ready, irq;
    logic [15:0] led_out;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit chk_en = 1'b0;

    io_responder dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .address   (address),
        .data      (data),
        .wren      (wren),
        .q         (q),
        .hit       (hit),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .evt_ready (evt_ready),
        .led_out   (led_out),
        .irq       (irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Model: timer as an absolute deadline in edge numbers, FIFO as a queue
    longint     m_t = 0;
    longint     m_deadline = 0;
    bit         m_running = 1'b0;
    bit         m_expired = 1'b0;
    bit         m_hit = 1'b0;
    logic [31:0] m_cycle = '0;
    logic [31:0] m_q = '0;
    logic [15:0] m_led = '0;
    logic [7:0]  m_fifo[$];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_t = 0;
            m_deadline = 0;
            m_running = 1'b0;
            m_expired = 1'b0;
            m_hit = 1'b0;
            m_cycle = '0;
            m_q = '0;
            m_led = '0;
            m_fifo.delete();
        end else begin : step
            logic [31:0] pre_count, rv;
            bit in_win, expire_now, can_push;
            m_t++;
            in_win    = req && (address[11:4] == 8'hF0);
            pre_count = m_running ? 32'(m_deadline - (m_t - 1)) : 32'd0;
            can_push  = evt_valid && (m_fifo.size() < 4);
            rv = 32'd0;
            case (address[3:0])
                4'd0: rv = m_cycle;
                4'd1: rv = pre_count;
                4'd2: rv = {30'd0, m_running, m_expired};
                4'd3: if (m_fifo.size() > 0) rv = {24'h800000, m_fifo[0]};
                4'd4: rv = 32'(m_fifo.size());
                4'd5: rv = {16'd0, m_led};
                default: rv = 32'd0;
            endcase
            expire_now = m_running && (m_deadline == m_t);
            if (expire_now) begin
                m_running = 1'b0;
                m_expired = 1'b1;
            end
            if (in_win && wren) begin
                case (address[3:0])
                    4'd1: begin
                        if (data != 32'd0) begin
                            m_running = 1'b1;
                            m_deadline = m_t + longint'(data);
                        end else begin
                            m_running = 1'b0;
                        end
                    end
                    4'd2: if (data[0] && !expire_now) m_expired = 1'b0;
                    4'd5: m_led = data[15:0];
                    default: ;
                endcase
            end
            if (in_win && !wren && (address[3:0] == 4'd3) && (m_fifo.size() > 0)) void'(m_fifo.pop_front());
            if (can_push) m_fifo.push_back(evt_data);
            m_cycle = m_cycle + 32'd1;
            if (req) begin
                m_hit = in_win;
                m_q = (in_win && !wren) ? rv : 32'd0;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("q", q, m_q);
            check("hit", 32'(hit), 32'(m_hit));
            check("irq", 32'(irq), 32'(m_expired));
            check("led_out", 32'(led_out), 32'(m_led));
            check("evt_ready", 32'(evt_ready), 32'(reset && (m_fifo.size() < 4)));
        end
    end

    task automatic cyc(input bit r, input bit w, input logic [11:0] a, input logic [31:0] d,
                       input bit ev, input logic [7:0] ed);
        @(negedge clock);
        #1;
        req = r; wren = w; address = a; data = d; evt_valid = ev; evt_data = ed;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 12'h000, 32'd0, 1'b0, 8'h00);
    endtask

    task automatic rd(input logic [11:0] a);
        cyc(1'b1, 1'b0, a, 32'd0, 1'b0, 8'h00);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b1, a, d, 1'b0, 8'h00);
    endtask

    task automatic rd_check(input string name, input logic [11:0] a, input logic [31:0] exp);
        rd(a);
        idle();
        check(name, q, exp);
    endtask

    initial begin
        logic [31:0] v1, v2, d;
        logic [11:0] a;
        bit r, w, ev;

        #1 reset = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check("rst_q", q, 32'd0);
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_led", 32'(led_out), 32'd0);
        check("rst_evt_ready", 32'(evt_ready), 32'd0);
        reset = 1'b1;

        rd(12'hF00);
        idle();
        v1 = q;
        repeat (8) idle();
        rd(12'hF00);
        idle();
        v2 = q;
        check("cycle_delta", v2 - v1, 32'd10);

        wr(12'hF01, 32'd5);
        rd(12'hF02);
        idle();
        check("status_running", q, 32'h2);
        idle();
        idle();
        idle();
        check("irq_before_expiry", 32'(irq), 32'd0);
        idle();
        check("irq_at_expiry", 32'(irq), 32'd1);
        rd_check("status_expired", 12'hF02, 32'h1);
        wr(12'hF02, 32'd1);
        idle();
        check("irq_cleared", 32'(irq), 32'd0);

        cyc(1'b0, 1'b0, 12'h000, 32'd0, 1'b1, 8'h11);
        cyc(1'b0, 1'b0, 12'h000, 32'd0, 1'b1, 8'h22);
        cyc(1'b0, 1'b0, 12'h000, 32'd0, 1'b1, 8'h33);
        cyc(1'b0, 1'b0, 12'h000, 32'd0, 1'b1, 8'h44);
        cyc(1'b0, 1'b0, 12'h000, 32'd0, 1'b1, 8'h55);
        check("full_evt_ready", 32'(evt_ready), 32'd0);
        cyc(1'b1, 1'b0, 12'hF04, 32'd0, 1'b1, 8'h55);
        cyc(1'b0, 1'b0, 12'h000, 32'd0, 1'b1, 8'h55);
        check("count_full", q, 32'd4);
        cyc(1'b1, 1'b0, 12'hF03, 32'd0, 1'b1, 8'h55);
        cyc(1'b0, 1'b0, 12'h000, 32'd0, 1'b1, 8'h55);
        check("pop_first", q, 32'h8000_0011);
        check("ready_after_pop", 32'(evt_ready), 32'd1);
        idle();
        rd_check("pop_22", 12'hF03, 32'h8000_0022);
        rd_check("pop_33", 12'hF03, 32'h8000_0033);
        cyc(1'b1, 1'b0, 12'hF03, 32'd0, 1'b1, 8'h66);
        idle();
        check("push_pop_head", q, 32'h8000_0044);
        rd_check("push_pop_count", 12'hF04, 32'd2);
        rd_check("pop_55", 12'hF03, 32'h8000_0055);
        rd_check("pop_66", 12'hF03, 32'h8000_0066);
        rd_check("pop_empty", 12'hF03, 32'd0);
        rd_check("count_empty", 12'hF04, 32'd0);
        cyc(1'b1, 1'b0, 12'hF03, 32'd0, 1'b1, 8'h77);
        idle();
        check("pop_empty_with_push", q, 32'd0);
        rd_check("count_after_push", 12'hF04, 32'd1);
        rd_check("pop_77", 12'hF03, 32'h8000_0077);

        wr(12'hF05, 32'hABCD_1234);
        idle();
        check("led_write", 32'(led_out), 32'h1234);
        rd_check("led_read", 12'hF05, 32'h0000_1234);
        check("led_read_hit", 32'(hit), 32'd1);
        wr(12'hE05, 32'h0000_BEEF);
        idle();
        check("outside_hit", 32'(hit), 32'd0);
        check("outside_led", 32'(led_out), 32'h1234);

        for (int i = 0; i < 1500; i++) begin
            r  = ($urandom_range(0, 9) < 6);
            w  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) < 8)
                a = {8'hF0, (($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5)))};
            else
                a = 12'($urandom);
            d  = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 12) : $urandom;
            ev = ($urandom_range(0, 9) < 4);
            cyc(r, w, a, d, ev, 8'($urandom));
        end

        repeat (5) rd(12'hF03);
        wr(12'hF05, 32'h0000_FFFF);
        wr(12'hF01, 32'd100);
        cyc(1'b0, 1'b0, 12'h000, 32'd0, 1'b1, 8'hA1);
        cyc(1'b0, 1'b0, 12'h000, 32'd0, 1'b1, 8'hA2);
        cyc(1'b0, 1'b0, 12'h000, 32'd0, 1'b1, 8'hA3);
        rd(12'hF04);
        idle();
        check("pre_reset_count", q, 32'd3);
        idle();
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_q", q, 32'd0);
        check("async_rst_hit", 32'(hit), 32'd0);
        check("async_rst_irq", 32'(irq), 32'd0);
        check("async_rst_led", 32'(led_out), 32'd0);
        check("async_rst_evt_ready", 32'(evt_ready), 32'd0);
        repeat (2) @(negedge clock);
        #1;
        reset = 1'b1;
        rd_check("post_rst_count", 12'hF04, 32'd0);
        rd_check("post_rst_timer", 12'hF01, 32'd0);
        rd_check("post_rst_status", 12'hF02, 32'd0);
        idle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
